// File: rtl/cordic_exp_pkg.sv
// Shared constants for the pipelined hyperbolic CORDIC exp() unit.
// Shift sequence, atanh table and angle saturation helper.
package cordic_exp_pkg;
  localparam int SZ = 8;
  localparam int NITER = 8;
  localparam int XW = 14;
  localparam int ZW = 12;
  localparam int OW = SZ + 2;
  localparam int OMAX = 2 ** OW - 1;

  localparam int SHIFT [0:NITER-1] =
    '{1, 2, 3, 4, 4, 5, 6, 7};
  localparam int ATANH_Q9 [0:NITER-1] =
    '{281, 131, 64, 32, 32, 16, 8, 4};

  localparam int ANG_MAX = 35;
  localparam int ANG_MIN = -35;

  // Clamp to the convergence range, then Q2.5 -> Q2.9.
  function automatic logic signed [ZW-1:0] sat_angle(
    input logic signed [SZ-1:0] a
  );
    logic signed [SZ-1:0] s;
    logic signed [ZW-1:0] w;
    if (a > ANG_MAX)
      s = SZ'(ANG_MAX);
    else if (a < ANG_MIN)
      s = SZ'(ANG_MIN);
    else
      s = a;
    w = {{(ZW-SZ){s[SZ-1]}}, s};
    return w <<< 4;
  endfunction
endpackage

// File: rtl/cordic_exponential_8bit_stage.sv
// One registered hyperbolic micro-rotation.
// Direction follows the sign of the residual angle.
module cordic_hyp_stage
  import cordic_exp_pkg::XW;
  import cordic_exp_pkg::ZW;
#(
  parameter int SHIFT = 1,
  parameter int ATANH = 281
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  output logic signed [XW-1:0] x_q,
  output logic signed [XW-1:0] y_q,
  output logic signed [ZW-1:0] z_q
);
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic                 pos;

  assign xs  = x >>> SHIFT;
  assign ys  = y >>> SHIFT;
  assign pos = ~z[ZW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (pos) begin
      x_q <= x + ys;
      y_q <= y + xs;
      z_q <= z - ZW'(ATANH);
    end else begin
      x_q <= x - ys;
      y_q <= y - xs;
      z_q <= z + ZW'(ATANH);
    end
  end
endmodule

// File: rtl/cordic_exponential_8bit.sv
// Streaming exp(z) = cosh(z) + sinh(z), one angle per clock.
// Input register, NITER rotations, rounding/saturating output register.
module cordic_exponential_8bit
  import cordic_exp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [SZ-1:0] angle,
  input  logic signed [SZ-1:0] Xin,
  input  logic signed [SZ-1:0] Yin,
  output logic        [OW-1:0] exp
);
  logic signed [XW-1:0] x0;
  logic signed [XW-1:0] y0;
  logic signed [ZW-1:0] z0;

  logic signed [XW-1:0] xs [0:NITER];
  logic signed [XW-1:0] ys [0:NITER];
  logic signed [ZW-1:0] zs [0:NITER];

  logic signed [XW:0] sum;
  logic signed [XW:0] rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else begin
      x0 <= {{(XW-SZ){Xin[SZ-1]}}, Xin} <<< 2;
      y0 <= {{(XW-SZ){Yin[SZ-1]}}, Yin} <<< 2;
      z0 <= sat_angle(angle);
    end
  end

  assign xs[0] = x0;
  assign ys[0] = y0;
  assign zs[0] = z0;

  for (genvar k = 0; k < NITER; k++) begin : g_rot
    cordic_hyp_stage #(
      .SHIFT (SHIFT[k]),
      .ATANH (ATANH_Q9[k])
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (xs[k]),
      .y     (ys[k]),
      .z     (zs[k]),
      .x_q   (xs[k+1]),
      .y_q   (ys[k+1]),
      .z_q   (zs[k+1])
    );
  end

  assign sum = xs[NITER] + ys[NITER];
  assign rnd = (sum + 15'sd2) >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      exp <= '0;
    else if (rnd < 0)
      exp <= '0;
    else if (rnd > OMAX)
      exp <= '1;
    else
      exp <= rnd[OW-1:0];
  end
endmodule

// File: tb/tb_cordic_exponential_8bit.sv
// Self-checking bench for cordic_exponential_8bit.
// Reference: integer CORDIC from the rule table plus real exp().
module tb_cordic_exponential_8bit;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] angle = '0;
  logic signed [7:0] xin = 8'sd77;
  logic signed [7:0] yin = '0;
  logic        [9:0] dut_exp;

  int checks = 0;
  int failures = 0;
  int pipe [0:9];

  cordic_exponential_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .angle (angle),
    .Xin   (xin),
    .Yin   (yin),
    .exp   (dut_exp)
  );

  always #5 clk = ~clk;

  function automatic int sat(int a);
    return (a > 35) ? 35 : ((a < -35) ? -35 : a);
  endfunction

  function automatic int model(int a, int xi, int yi);
    int sh [8] = '{1, 2, 3, 4, 4, 5, 6, 7};
    int at [8] = '{281, 131, 64, 32, 32, 16, 8, 4};
    int x, y, z, xn, r;
    z = sat(a) * 16;
    x = xi * 4;
    y = yi * 4;
    for (int i = 0; i < 8; i++) begin
      if (z >= 0) begin
        xn = x + (y >>> sh[i]);
        y  = y + (x >>> sh[i]);
        z  = z - at[i];
      end else begin
        xn = x - (y >>> sh[i]);
        y  = y - (x >>> sh[i]);
        z  = z + at[i];
      end
      x = xn;
    end
    r = (x + y + 2) >>> 2;
    if (r < 0) r = 0;
    if (r > 1023) r = 1023;
    return r;
  endfunction

  // Expected output stream: newest sample at [0], 10-edge latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) pipe[i] <= 0;
    end else begin
      pipe[0] <= model(int'(angle), int'(xin), int'(yin));
      for (int i = 1; i < 10; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic test_reset;
    #1;
    checks++;
    if (dut_exp !== 10'd0) begin
      failures++;
      $display("FAIL reset_t0 got=%0d want=0", dut_exp);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_exp !== 10'd0) begin
      failures++;
      $display("FAIL reset_held got=%0d want=0", dut_exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_points;
    int pa [9] = '{0, 32, -32, 16, -16, 35, 127, -35, -128};
    int pt [9] = '{2, 3, 2, 2, 2, 3, 3, 2, 2};
    int res [9];
    real ideal, diff;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      angle = 8'(pa[i]);
      xin = 8'sd77;
      yin = 8'sd0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      res[i] = int'(dut_exp);
      checks++;
      if (res[i] != model(pa[i], 77, 0)) begin
        failures++;
        $display("FAIL point_exact a=%0d got=%0d want=%0d",
                 pa[i], res[i], model(pa[i], 77, 0));
      end
      ideal = 64.0 * $exp(real'(sat(pa[i])) / 32.0);
      diff = real'(res[i]) - ideal;
      if (diff < 0.0) diff = -diff;
      checks++;
      if (diff > real'(pt[i])) begin
        failures++;
        $display("FAIL point_tol a=%0d got=%0d want=%0.2f+/-%0d",
                 pa[i], res[i], ideal, pt[i]);
      end
    end
    checks++;
    if (res[6] != res[5]) begin
      failures++;
      $display("FAIL sat_pos got=%0d want=%0d", res[6], res[5]);
    end
    checks++;
    if (res[8] != res[7]) begin
      failures++;
      $display("FAIL sat_neg got=%0d want=%0d", res[8], res[7]);
    end
  endtask

  task automatic test_ramp;
    for (int a = -128; a < 138; a++) begin
      @(negedge clk);
      checks++;
      if (dut_exp !== pipe[9][9:0] || pipe[9] > 1023) begin
        failures++;
        $display("FAIL ramp step=%0d got=%0d want=%0d",
                 a, dut_exp, pipe[9]);
      end
      angle = 8'((a < 128) ? a : 0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (dut_exp !== pipe[9][9:0]) begin
        failures++;
        $display("FAIL random i=%0d got=%0d want=%0d",
                 i, dut_exp, pipe[9]);
      end
      angle = 8'($urandom_range(255));
      xin = 8'($urandom_range(255));
      yin = 8'($urandom_range(255));
    end
  endtask

  task automatic test_midreset;
    int a0;
    int want;
    xin = 8'sd77;
    yin = 8'sd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      angle = 8'(i * 3 - 30);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_exp !== 10'd0) begin
      failures++;
      $display("FAIL midreset_async got=%0d want=0", dut_exp);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    a0 = 20;
    angle = 8'(a0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      want = (k < 10) ? 0 : model(a0, 77, 0);
      checks++;
      if (dut_exp !== 10'(want)) begin
        failures++;
        $display("FAIL midreset edge=%0d got=%0d want=%0d",
                 k, dut_exp, want);
      end
      angle = 8'($urandom_range(255));
    end
  endtask

  task automatic test_zero;
    xin = 8'sd0;
    yin = 8'sd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i >= 11) begin
        checks++;
        if (dut_exp !== 10'd0) begin
          failures++;
          $display("FAIL zero_vec i=%0d got=%0d want=0", i, dut_exp);
        end
      end
      angle = 8'($urandom_range(255));
    end
    angle = 8'sd0;
    xin = -8'sd77;
    repeat (11) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_exp !== 10'd0) begin
      failures++;
      $display("FAIL neg_clamp got=%0d want=0", dut_exp);
    end
  endtask

  initial begin
    test_reset;
    test_points;
    test_ramp;
    test_random;
    test_midreset;
    test_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
